// File: rtl/dmx_pkg.sv
// dmx_pkg: shared DMX512 frame-generator types and protocol constants.
package dmx_pkg;
    typedef enum logic [2:0] {IDLE, BREAK, MAB, START, DATA, STOP, MTBS} state_t;
    localparam int DMX_MAX_SLOTS      = 512;
    localparam int DMX_STOP_BITS      = 2;
    localparam int DMX_MIN_BREAK_BITS = 22;
endpackage

// File: rtl/dmx_bit_timer.sv
// dmx_bit_timer: bit-period tick generator with a loadable bit-count down-counter.
module dmx_bit_timer #(
    parameter int BIT_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] bits,
    output logic        tick,
    output logic        done
);
    localparam int TW = BIT_TICKS > 1 ? $clog2(BIT_TICKS) : 1;

    logic [TW-1:0] tick_cnt;
    logic [15:0]   bit_cnt;

    assign tick = tick_cnt == TW'(BIT_TICKS - 1);
    assign done = tick && bit_cnt == 16'd1;

    // load restarts the bit phase so every timed state lasts exactly bits*BIT_TICKS cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            tick_cnt <= '0;
            bit_cnt  <= bits;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick && bit_cnt != 16'd0) bit_cnt <= bit_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/dmx_frame_gen.sv
// dmx_frame_gen: DMX512 transmitter producing break, MAB, start code and N fetched data slots.
// Define DMX_GEN_STATS_EN to add the wrapping frame_cnt output.
module dmx_frame_gen
    import dmx_pkg::*;
#(
    parameter int  CLK_HZ     = 16000000,
    parameter int  BAUD       = 250000,
    parameter int  BREAK_BITS = 23,
    parameter int  MAB_BITS   = 3,
    parameter int  MAX_SLOTS  = DMX_MAX_SLOTS,
    localparam int SW         = $clog2(MAX_SLOTS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic [7:0]    start_code,
    input  logic [SW-1:0] slot_count,
    input  logic [7:0]    mtbs,
    output logic          rd_en,
    output logic [SW-2:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          tx,
    output logic          tx_en,
    output logic          busy,
`ifdef DMX_GEN_STATS_EN
    output logic [31:0]   frame_cnt,
`endif
    output logic          frame_done
);
    localparam int BIT_TICKS = CLK_HZ / BAUD;

    state_t        state, state_d;
    logic [SW-1:0] cnt_q, slot;
    logic [7:0]    mtbs_q, shreg;
    logic          cap_q, load, sample, fetch, next_slot, fin, tick, done, more;
    logic [15:0]   load_bits;

    dmx_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .bits (load_bits),
        .tick (tick),
        .done (done)
    );

    assign more  = slot < cnt_q;
    assign busy  = state != IDLE;
    assign tx_en = busy;
    assign tx    = (state == BREAK || state == START) ? 1'b0 : state == DATA ? shreg[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        load_bits = '0;
        sample    = 1'b0;
        fetch     = 1'b0;
        next_slot = 1'b0;
        fin       = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_d   = BREAK;
                load      = 1'b1;
                load_bits = 16'(BREAK_BITS);
                sample    = 1'b1;
            end
            BREAK: if (done) begin
                state_d   = MAB;
                load      = 1'b1;
                load_bits = 16'(MAB_BITS);
            end
            MAB, MTBS: if (done) begin
                state_d   = START;
                load      = 1'b1;
                load_bits = 16'd1;
            end
            START: if (done) begin
                state_d   = DATA;
                load      = 1'b1;
                load_bits = 16'd8;
            end
            DATA: if (done) begin
                state_d   = STOP;
                load      = 1'b1;
                load_bits = 16'(DMX_STOP_BITS);
                fetch     = more;
            end
            STOP: if (done) begin
                load = more || cont;
                if (more) begin
                    next_slot = 1'b1;
                    state_d   = mtbs_q != 8'd0 ? MTBS : START;
                    load_bits = mtbs_q != 8'd0 ? {8'd0, mtbs_q} : 16'd1;
                end else begin
                    fin       = 1'b1;
                    state_d   = cont ? BREAK : IDLE;
                    load_bits = 16'(BREAK_BITS);
                    sample    = cont;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // slot holds the index of the slot on the wire; slot 0 is the start code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mtbs_q     <= '0;
            shreg      <= '0;
            slot       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            cap_q      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_en      <= fetch;
            cap_q      <= rd_en;
            frame_done <= fin;
            if (fetch) rd_addr <= slot[SW-2:0];
            if (next_slot) slot <= slot + 1'b1;
            if (sample) begin
                cnt_q  <= slot_count > SW'(MAX_SLOTS) ? SW'(MAX_SLOTS) : slot_count;
                mtbs_q <= mtbs;
                shreg  <= start_code;
                slot   <= '0;
            end else if (cap_q) begin
                shreg <= rd_data;
            end else if (state == DATA && tick) begin
                shreg <= shreg >> 1;
            end
        end
    end

`ifdef DMX_GEN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         frame_cnt <= '0;
        else if (fin)       frame_cnt <= frame_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmx_frame_gen.sv
// tb_dmx_frame_gen: directed checks of DMX frame timing, slot content, cont mode and reset.
module tb_dmx_frame_gen;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0;
    logic [7:0] start_code = '0, mtbs = '0, rd_data = '0;
    logic [9:0] slot_count = '0;
    logic [8:0] rd_addr;
    logic       rd_en, tx, tx_en, busy, frame_done;
`ifdef DMX_GEN_STATS_EN
    logic [31:0] frame_cnt;
`endif
    int   vectors = 0, miscompares = 0;
    int   n, fd, re;
    logic wave [0:23999];

    dmx_frame_gen #(.CLK_HZ(1000000), .BAUD(250000), .BREAK_BITS(23), .MAB_BITS(3), .MAX_SLOTS(512)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .start_code(start_code),
        .slot_count(slot_count),
        .mtbs      (mtbs),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx        (tx),
        .tx_en     (tx_en),
        .busy      (busy),
`ifdef DMX_GEN_STATS_EN
        .frame_cnt (frame_cnt),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= 8'({1'b0, rd_addr} + 10'd16);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // records tx once per cycle until frame_done; n ends as the busy length in cycles
    task automatic wait_frame(input int budget, input int inject);
        n = 0; fd = 0; re = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = (i == inject);
            if (frame_done) begin
                fd++;
                break;
            end
            wave[n] = tx;
            n++;
            if (rd_en) re++;
        end
        if (fd == 0) check("timeout", 0, 1);
    endtask

    task automatic run(input logic [7:0] sc, input logic [9:0] cnt, input logic [7:0] m, input int budget, input int inject);
        start_code = sc; slot_count = cnt; mtbs = m; start = 1'b1;
        wait_frame(budget, inject);
    endtask

    function automatic logic [31:0] slot_at(input int base);
        logic [10:0] r;
        for (int j = 0; j < 11; j++) r[j] = wave[base + 4 * j + 2];
        return {21'd0, r};
    endfunction

    function automatic logic [31:0] frm(input logic [7:0] b);
        return {21'd0, 2'b11, b, 1'b0};
    endfunction

    function automatic int run_len(input int p);
        int k = 0;
        while (p + k < n && wave[p + k] == wave[p]) k++;
        return k;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outs", {27'd0, tx, tx_en, busy, frame_done, rd_en}, 32'b10000);
        check("rst_addr", rd_addr, 0);
        rst_n = 1'b1;

        run(8'h00, 10'd3, 8'd0, 400, -1);
        check("f1_len", n, 280);
        check("f1_break", run_len(0), 92);
        check("f1_mab", run_len(92), 12);
        check("f1_s0", slot_at(104), frm(8'h00));
        check("f1_s1", slot_at(148), frm(8'h10));
        check("f1_s2", slot_at(192), frm(8'h11));
        check("f1_s3", slot_at(236), frm(8'h12));
        check("f1_rd", re, 3);
        check("f1_idle", {29'd0, tx, tx_en, busy}, 32'b100);

        run(8'hCC, 10'd0, 8'd0, 400, -1);
        check("f2_len", n, 148);
        check("f2_s0", slot_at(104), frm(8'hCC));
        check("f2_rd", re, 0);

        run(8'h55, 10'd2, 8'd2, 400, -1);
        check("f3_len", n, 252);
        check("f3_mark", run_len(140), 16);
        check("f3_s0", slot_at(104), frm(8'h55));
        check("f3_s1", slot_at(156), frm(8'h10));
        check("f3_s2", slot_at(208), frm(8'h11));

        cont = 1'b1;
        run(8'hA5, 10'd1, 8'd0, 400, -1);
        check("c1_len", n, 192);
        check("c1_s1", slot_at(148), frm(8'h10));
        check("c1_nogap", {30'd0, busy, tx}, 32'b10);
        cont = 1'b0;
        start_code = 8'h3C;
        wait_frame(400, -1);
        check("c2_len", n, 191);
        check("c2_s1", slot_at(147), frm(8'h10));
        check("c2_txen", tx_en, 0);

        start_code = 8'h00; slot_count = 10'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (330) @(negedge clk);
        check("mid_txen", tx_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {27'd0, tx, tx_en, busy, rd_en, frame_done}, 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h3C, 10'd3, 8'd0, 400, -1);
        check("r_len", n, 280);
        check("r_s0", slot_at(104), frm(8'h3C));
        check("r_s3", slot_at(236), frm(8'h12));

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h01, 10'd600, 8'd0, 23500, 500);
        check("big_len", n, 22676);
        check("big_rd", re, 512);
        check("big_s100", slot_at(4504), frm(8'h73));
        check("big_s512", slot_at(22632), frm(8'h0F));
        @(negedge clk);
        check("big_idle", busy, 0);
`ifdef DMX_GEN_STATS_EN
        check("frame_cnt", frame_cnt, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
